adder_nibble_sequencer: RTL
===========================

Name: adder_nibble_sequencer

Overview:
- Multi-cycle wide adder controller. It sequences one shared 4-bit ripple-carry slice over a WIDTH-bit operand pair, one nibble per clock, LSB nibble first, and chains the carry through a carry register.
- Sits between a requester (start/done handshake) and the 4-bit adder datapath. It trades latency for area on wide additions.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
- NIBBLES, WIDTH/4, derived localparam giving the number of slice iterations; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  registered result; held between operations.
- cout  output  1  registered carry-out of the MSB nibble.
- ovf  output  1  signed overflow; port exists only with OVF_DETECT_EN.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand shift registers, carry register and nibble counter are cleared to 0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge: latch a, b into operand shift registers, cin into carry register, counter=0, go to ADD.
  - start=0: stay in IDLE.
- ADD: at each edge:
  - {c, s4} = opA[3:0] + opB[3:0] + carry, computed 5 bits wide with no truncation of the carry.
  - s4 shifts into the top of the partial-result register, which shifts right by 4.
  - opA and opB shift right by 4; carry <= c; counter++.
  - At the edge that processes nibble NIBBLES-1: copy the full partial result to sum, c to cout, go to DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: done is high in the cycle after the NIBBLES-th edge following the start-accept edge (WIDTH=16: 4 edges). The next start can be accepted at the edge leaving DONE+1, i.e. in IDLE. Throughput is 1 op per NIBBLES+2 cycles.
- start while busy=1 (ADD or DONE) is ignored; no queuing, no error flag.
- a/b/cin changes after the accept edge have no effect on the in-flight operation.
- sum/cout change only on the ADD->DONE transition and hold through IDLE until the next completion. No partial values are visible on the outputs during ADD.
- Wrap-around: the result is modulo 2^WIDTH; the carry out of the top nibble appears only on cout.
- Reset mid-operation (any state) aborts the operation, returns to IDLE, zeroes all outputs, and no done pulse is produced.
- Simultaneous reset and start: reset wins, and start is not accepted on that edge.

Optional Feature:
- Macro: OVF_DETECT_EN.
- Defined:
  - ovf port is present.
  - ovf <= (a[WIDTH-1]==b[WIDTH-1]) && (result[WIDTH-1]!=a[WIDTH-1]), using the latched operand sign bits.
  - Registered on the ADD->DONE edge alongside sum, held identically, cleared by reset.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Default WIDTH=16. a=16'h1234, b=16'h4321, cin=0, start pulse → after 4 edges done=1 for one cycle, sum=16'h5555, cout=0. busy=1 from accept edge through the DONE cycle.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1. The carry propagates across all 4 nibbles.
- Start ignored while busy: accept a=16'h0001, b=16'h0001. Pulse start with a=16'hAAAA during ADD → result sum=16'h0002. No second done pulse; busy falls after the single DONE cycle.
- Reset mid-op: accept a=16'hFFFF, b=16'h0001. Assert reset on the 2nd ADD edge → busy=0, done never pulses, sum=0, cout=0. A new start then gives the correct result.
- Hold and back-to-back: sum=16'h5555 held unchanged for 10 idle cycles. Start on the first IDLE cycle after DONE with a=16'h8000, b=16'h8000 → sum=16'h0000, cout=1. With OVF_DETECT_EN: ovf=1, and 16'h4000+16'h4000 gives ovf=1, sum=16'h8000.
- WIDTH=8 instance: a=8'hF0, b=8'h10, cin=0 → done after 2 edges, sum=8'h00, cout=1.

Source files
------------

// File: rtl/adder_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit slice, one nibble per clock, LSB first.
// Optional signed-overflow output enabled by defining OVF_DETECT_EN.
module adder_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       slice_sum;

`ifdef OVF_DETECT_EN
    // Operand sign bits are shifted out of the operand registers, so keep a copy.
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;
    logic ovf_q, ovf_d;
`endif

    assign slice_sum = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'b0000, carry_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef OVF_DETECT_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef OVF_DETECT_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef OVF_DETECT_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_ADD;
`ifdef OVF_DETECT_EN
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
`endif
                end
            end
            S_ADD: begin
                opa_d   = opa_q >> 4;
                opb_d   = opb_q >> 4;
                part_d  = {slice_sum[3:0], part_q[WIDTH-1:4]};
                carry_d = slice_sum[4];
                cnt_d   = cnt_q + 1'b1;
                // Outputs only update once the top nibble has been folded in.
                if (cnt_q == LAST_NIB) begin
                    sum_d   = part_d;
                    cout_d  = slice_sum[4];
                    state_d = S_DONE;
`ifdef OVF_DETECT_EN
                    ovf_d = (sign_a_q == sign_b_q) && (slice_sum[3] != sign_a_q);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef OVF_DETECT_EN
    assign ovf  = ovf_q;
`endif

endmodule
